// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM encoding, digit maxima
// and nibble offsets of each digit inside bcd_num.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_TENS_MAX = 5;
    localparam int UNITS_MAX    = 9;

    localparam int SEC_UNITS_LSB = 0;
    localparam int SEC_TENS_LSB  = 4;
    localparam int MIN_UNITS_LSB = 8;
    localparam int MIN_TENS_LSB  = 12;

    // A divide-by-1 prescaler still needs a 1-bit register.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit counting 0..MAX; carry is combinational so digits ripple within one cycle.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    localparam logic [3:0] MAX_V = 4'(MAX);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = 4'd0;
        else if (inc)
            q_d = (q_q == MAX_V) ? 4'd0 : q_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= 4'd0;
        else     q_q <= q_d;
    end

    assign q     = q_q;
    assign carry = inc & (q_q == MAX_V);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch: 1 Hz prescaler, IDLE/RUN/PAUSE control and an MM:SS BCD chain.
// Optional lap hold freezes the display while counting continues (macro LAP_HOLD_EN).
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] bcd_num,
    output logic        running,
    output logic        wrap,
    output logic        lap_active
);

    localparam int             CLK_DIV   = CLK_HZ / TICK_HZ;
    localparam int             PW        = presc_width(CLK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   bcd_num_q, bcd_num_d;
    logic          running_q, wrap_q, hold_q, hold_d;
    logic          sec_tick;

    logic [3:0]  su_q, st_q, mu_q, mt_q;
    logic        inc_su, c_su, c_st, c_mu, c_mt;
    logic [15:0] live;

    assign sec_tick = (state_q == RUN) && (presc_q == PRESC_MAX);
    // A clear in the tick cycle wins: no increment, no wrap.
    assign inc_su   = sec_tick & ~clear;

    bcd_digit #(.MAX(UNITS_MAX)) u_sec_units (
        .clk(clk), .rst(rst), .clr(clear), .inc(inc_su), .q(su_q), .carry(c_su)
    );
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(c_su), .q(st_q), .carry(c_st)
    );
    bcd_digit #(.MAX(UNITS_MAX)) u_min_units (
        .clk(clk), .rst(rst), .clr(clear), .inc(c_st), .q(mu_q), .carry(c_mu)
    );
    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(c_mu), .q(mt_q), .carry(c_mt)
    );

    always_comb begin
        live = 16'h0000;
        live[SEC_UNITS_LSB +: 4] = su_q;
        live[SEC_TENS_LSB  +: 4] = st_q;
        live[MIN_UNITS_LSB +: 4] = mu_q;
        live[MIN_TENS_LSB  +: 4] = mt_q;
    end

`ifndef LAP_HOLD_EN
    logic unused_lap;
    assign unused_lap = lap;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        hold_d  = hold_q;
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
            hold_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (start_stop) state_d = RUN;
                RUN: begin
                    presc_d = sec_tick ? '0 : presc_q + 1'b1;
                    if (start_stop) state_d = PAUSE;
                end
                PAUSE:   if (start_stop) state_d = RUN;
                default: state_d = IDLE;
            endcase
`ifdef LAP_HOLD_EN
            if (lap && state_q != IDLE) hold_d = ~hold_q;
`endif
        end
        // Holding reuses the displayed value itself as the lap snapshot.
        if (clear)
            bcd_num_d = 16'h0000;
        else if (hold_d)
            bcd_num_d = bcd_num_q;
        else
            bcd_num_d = live;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            bcd_num_q <= 16'h0000;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            bcd_num_q <= bcd_num_d;
            running_q <= (state_d == RUN);
            wrap_q    <= c_mt;
            hold_q    <= hold_d;
        end
    end

    assign bcd_num    = bcd_num_q;
    assign running    = running_q;
    assign wrap       = wrap_q;
    assign lap_active = hold_q;

endmodule
